geri_yazma_birimi: RTL and testbench
====================================

Name: geri_yazma_birimi

Overview:
- Write-back collector sitting downstream of the AMB and the memory unit. It consumes AMB results (sonuc + destination register) and memory load data, and arbitrates the single register-file write port.
- AMB results that lose arbitration are held in an in-order FIFO.
- When the FIFO is full, the block drives a stall back to the AMB's durdur_i.

Parameters:
DERINLIK, 2, AMB result FIFO depth in entries (power of two, >=2)
VERI_GENISLIGI, 32, result data width
HEDEF_GENISLIGI, 5, destination register index width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
amb_gecerli_i  in  1  AMB result valid (driven from AMB_hazir_o)
amb_sonuc_i  in  VERI_GENISLIGI  AMB result (from sonuc_o)
amb_hedef_i  in  HEDEF_GENISLIGI  destination register of the AMB result
bellek_gecerli_i  in  1  memory load data valid
bellek_veri_i  in  VERI_GENISLIGI  load data
bellek_hedef_i  in  HEDEF_GENISLIGI  destination register of the load
durdur_o  out  1  stall to AMB durdur_i; combinational, equals FIFO full
yaz_gecerli_o  out  1  register-file write enable (registered)
yaz_adres_o  out  HEDEF_GENISLIGI  register-file write address (registered)
yaz_veri_o  out  VERI_GENISLIGI  register-file write data (registered)
bekleyen_sayisi_o  out  $clog2(DERINLIK)+1  current FIFO occupancy

Behaviour:
- Reset (rst_i=1, async): FIFO pointers and count cleared; all outputs 0, including yaz_gecerli_o=0 and durdur_o=0. Reset asserted mid-operation discards every queued entry and any pending write.

Acceptance:
- The AMB result is accepted in a cycle iff amb_gecerli_i=1 and durdur_o=0.
- While durdur_o=1, the AMB holds its output and re-presents the same result. That re-presented result must not be enqueued or written, so no duplicate write occurs.
- Results with destination 0 are accepted (when durdur_o=0) but dropped: no enqueue, no write.
- A load with bellek_hedef_i=0 is dropped and does not occupy the write port.

Write-port arbitration (one write per cycle, priority high to low):
1. Load with nonzero destination.
2. FIFO head.
3. Accepted AMB result directly (bypass), only when the FIFO is empty.

- The selected source is registered into yaz_* at the clock edge. Latency is 1 cycle from input to yaz_gecerli_o; there is no write in cycles where nothing is selected (yaz_gecerli_o=0, address/data hold last value).
- An accepted AMB result with nonzero destination that is not written directly is enqueued at the tail in the same edge.
- Ordering: AMB results are written in acceptance order. No bypass is allowed while the FIFO is non-empty.

FIFO:
- Circular buffer with wrap-around read/write pointers.
- Count updates by +1 (enqueue only), -1 (dequeue only), or 0 (both, or neither).
- Enqueue and dequeue in the same cycle are legal when not full.
- When full, durdur_o=1, so no enqueue occurs. A dequeue in that cycle drops durdur_o in the next cycle.
- Dequeue never occurs when empty.

bekleyen_sayisi_o: equals the count register.

Hazard note: same-destination ordering between a load and queued AMB results is the issue logic's responsibility. This block does not reorder or merge entries.

Test Plan:
- Reset: assert rst_i with no clock edge -> yaz_gecerli_o=0, durdur_o=0 and bekleyen_sayisi_o=0 immediately. After release with idle inputs, all outputs stay 0.
- Bypass: AMB result 0x0000_00AA to x5 with FIFO empty and no load -> next cycle yaz_gecerli_o=1, yaz_adres_o=5, yaz_veri_o=0xAA; bekleyen_sayisi_o stays 0.
- Collision: same cycle, AMB 0x11 to x3 and load 0x22 to x4 -> cycle+1 write x4=0x22 with count=1; cycle+2 write x3=0x11 with count=0.
- Fill/stall: loads on 3 consecutive cycles while AMB presents 0x1, 0x2, 0x3 to x1, x2, x3 ->
  - count reaches 2 and durdur_o=1;
  - 0x3 is held by the AMB and not enqueued;
  - once loads stop, writes occur in order x1=0x1, x2=0x2, x3=0x3, each exactly once.
- Destination zero: AMB 0xFFFF_FFFF to x0 and load to x0 -> no yaz_gecerli_o pulse, count unchanged.
- Wrap-around and reset mid-operation:
  - Step 1: 5 alternating collisions (pointers wrap) -> writes match the input order exactly.
  - Step 2: fill the FIFO with 2 entries, then assert rst_i -> count=0, durdur_o=0, and no queued writes appear after release.

Source files
------------

// File: rtl/geri_yazma_birimi.sv
// Write-back collector: arbitrates the single register-file write port between
// memory loads, queued AMB results and directly bypassed AMB results.
module geri_yazma_birimi #(
    parameter int DERINLIK        = 2,
    parameter int VERI_GENISLIGI  = 32,
    parameter int HEDEF_GENISLIGI = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         amb_gecerli_i,
    input  logic [VERI_GENISLIGI-1:0]    amb_sonuc_i,
    input  logic [HEDEF_GENISLIGI-1:0]   amb_hedef_i,
    input  logic                         bellek_gecerli_i,
    input  logic [VERI_GENISLIGI-1:0]    bellek_veri_i,
    input  logic [HEDEF_GENISLIGI-1:0]   bellek_hedef_i,
    output logic                         durdur_o,
    output logic                         yaz_gecerli_o,
    output logic [HEDEF_GENISLIGI-1:0]   yaz_adres_o,
    output logic [VERI_GENISLIGI-1:0]    yaz_veri_o,
    output logic [$clog2(DERINLIK):0]    bekleyen_sayisi_o
);

    localparam int PW = $clog2(DERINLIK);
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {
        KAYNAK_YOK,
        KAYNAK_BELLEK,
        KAYNAK_FIFO,
        KAYNAK_AMB
    } kaynak_e;

    logic [VERI_GENISLIGI-1:0]  r_veri_mem  [DERINLIK];
    logic [HEDEF_GENISLIGI-1:0] r_hedef_mem [DERINLIK];
    logic [PW-1:0]              r_oku_ptr;
    logic [PW-1:0]              r_yaz_ptr;
    logic [SW-1:0]              r_sayac;

    logic                       r_yaz_gecerli;
    logic [HEDEF_GENISLIGI-1:0] r_yaz_adres;
    logic [VERI_GENISLIGI-1:0]  r_yaz_veri;

    logic    w_dolu;
    logic    w_bos;
    logic    w_amb_kabul;
    logic    w_amb_yazilir;
    logic    w_yukle;
    logic    w_enq;
    logic    w_deq;
    kaynak_e w_kaynak;

    assign w_dolu  = (r_sayac == SW'(DERINLIK));
    assign w_bos   = (r_sayac == '0);

    // A result re-presented while stalled is never accepted, so no duplicate write.
    assign w_amb_kabul   = amb_gecerli_i && !w_dolu;
    assign w_amb_yazilir = w_amb_kabul && (amb_hedef_i != '0);
    assign w_yukle       = bellek_gecerli_i && (bellek_hedef_i != '0);

    // Bypass only on an empty FIFO keeps AMB results in acceptance order.
    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        w_kaynak = KAYNAK_YOK;
        if (w_yukle) begin
            w_kaynak = KAYNAK_BELLEK;
        end else if (!w_bos) begin
            w_kaynak = KAYNAK_FIFO;
        end else if (w_amb_yazilir) begin
            w_kaynak = KAYNAK_AMB;
        end
    end

    assign w_deq = (w_kaynak == KAYNAK_FIFO);
    assign w_enq = w_amb_yazilir && (w_kaynak != KAYNAK_AMB);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oku_ptr <= '0;
            r_yaz_ptr <= '0;
            r_sayac   <= '0;
        end else begin
            if (w_enq) begin
                r_yaz_ptr <= r_yaz_ptr + PW'(1);
            end
            if (w_deq) begin
                r_oku_ptr <= r_oku_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_sayac <= r_sayac + SW'(1);
                2'b01:   r_sayac <= r_sayac - SW'(1);
                default: r_sayac <= r_sayac;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_veri_mem[r_yaz_ptr]  <= amb_sonuc_i;
            r_hedef_mem[r_yaz_ptr] <= amb_hedef_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_yaz_gecerli <= 1'b0;
            r_yaz_adres   <= '0;
            r_yaz_veri    <= '0;
        end else begin
            r_yaz_gecerli <= (w_kaynak != KAYNAK_YOK);
            case (w_kaynak)
                KAYNAK_BELLEK: begin
                    r_yaz_adres <= bellek_hedef_i;
                    r_yaz_veri  <= bellek_veri_i;
                end
                KAYNAK_FIFO: begin
                    r_yaz_adres <= r_hedef_mem[r_oku_ptr];
                    r_yaz_veri  <= r_veri_mem[r_oku_ptr];
                end
                KAYNAK_AMB: begin
                    r_yaz_adres <= amb_hedef_i;
                    r_yaz_veri  <= amb_sonuc_i;
                end
                default: begin
                    r_yaz_adres <= r_yaz_adres;
                    r_yaz_veri  <= r_yaz_veri;
                end
            endcase
        end
    end

    assign durdur_o          = w_dolu;
    assign yaz_gecerli_o     = r_yaz_gecerli;
    assign yaz_adres_o       = r_yaz_adres;
    assign yaz_veri_o        = r_yaz_veri;
    assign bekleyen_sayisi_o = r_sayac;

endmodule

// File: tb/tb_geri_yazma_birimi.sv
// Bench for geri_yazma_birimi: per-cycle vector table with an expected-write
// scoreboard, plus hand-written reset sequences.
module tb_geri_yazma_birimi;

    logic        clk_i;
    logic        rst_i;
    logic        amb_gecerli_i;
    logic [31:0] amb_sonuc_i;
    logic [4:0]  amb_hedef_i;
    logic        bellek_gecerli_i;
    logic [31:0] bellek_veri_i;
    logic [4:0]  bellek_hedef_i;
    logic        durdur_o;
    logic        yaz_gecerli_o;
    logic [4:0]  yaz_adres_o;
    logic [31:0] yaz_veri_o;
    logic [1:0]  bekleyen_sayisi_o;

    geri_yazma_birimi #(
        .DERINLIK        (2),
        .VERI_GENISLIGI  (32),
        .HEDEF_GENISLIGI (5)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .amb_gecerli_i     (amb_gecerli_i),
        .amb_sonuc_i       (amb_sonuc_i),
        .amb_hedef_i       (amb_hedef_i),
        .bellek_gecerli_i  (bellek_gecerli_i),
        .bellek_veri_i     (bellek_veri_i),
        .bellek_hedef_i    (bellek_hedef_i),
        .durdur_o          (durdur_o),
        .yaz_gecerli_o     (yaz_gecerli_o),
        .yaz_adres_o       (yaz_adres_o),
        .yaz_veri_o        (yaz_veri_o),
        .bekleyen_sayisi_o (bekleyen_sayisi_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        amb_v;
        logic [31:0] amb_d;
        logic [4:0]  amb_h;
        logic        mem_v;
        logic [31:0] mem_d;
        logic [4:0]  mem_h;
        logic        wr_v;
        logic [4:0]  wr_a;
        logic [31:0] wr_d;
        logic [1:0]  cnt;
        logic        dd;
    } vec_t;

    typedef struct {
        logic [4:0]  adres;
        logic [31:0] veri;
    } yazma_t;

    vec_t   tbl[$];
    yazma_t sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic amb_v, input logic [31:0] amb_d, input logic [4:0] amb_h,
                                input logic mem_v, input logic [31:0] mem_d, input logic [4:0] mem_h,
                                input logic wr_v, input logic [4:0] wr_a, input logic [31:0] wr_d,
                                input logic [1:0] cnt, input logic dd);
        vec_t v;
        v.amb_v = amb_v; v.amb_d = amb_d; v.amb_h = amb_h;
        v.mem_v = mem_v; v.mem_d = mem_d; v.mem_h = mem_h;
        v.wr_v  = wr_v;  v.wr_a  = wr_a;  v.wr_d  = wr_d;
        v.cnt   = cnt;   v.dd    = dd;
        return v;
    endfunction

    task automatic drive_idle();
        amb_gecerli_i    = 1'b0;
        amb_sonuc_i      = '0;
        amb_hedef_i      = '0;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i    = '0;
        bellek_hedef_i   = '0;
    endtask

    // Pops the scoreboard whenever the DUT writes; a write with nothing expected fails.
    task automatic score_write(input string tag);
        yazma_t e;
        if (yaz_gecerli_o) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected_write"}, 32'(yaz_gecerli_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check({tag, "_wr_addr"}, 32'(yaz_adres_o), 32'(e.adres));
                check({tag, "_wr_data"}, yaz_veri_o, e.veri);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        yazma_t e;
        amb_gecerli_i    = v.amb_v;
        amb_sonuc_i      = v.amb_d;
        amb_hedef_i      = v.amb_h;
        bellek_gecerli_i = v.mem_v;
        bellek_veri_i    = v.mem_d;
        bellek_hedef_i   = v.mem_h;
        if (v.wr_v) begin
            e.adres = v.wr_a;
            e.veri  = v.wr_d;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        check($sformatf("row%0d_wr_valid", idx), 32'(yaz_gecerli_o), 32'(v.wr_v));
        check($sformatf("row%0d_count", idx), 32'(bekleyen_sayisi_o), 32'(v.cnt));
        check($sformatf("row%0d_stall", idx), 32'(durdur_o), 32'(v.dd));
        score_write($sformatf("row%0d", idx));
    endtask

    initial begin
        rst_i = 1'b0;
        drive_idle();

        // Reset before any clock edge must clear the outputs at once.
        #2 rst_i = 1'b1;
        #1;
        check("rst_async_wr_valid", 32'(yaz_gecerli_o), 32'd0);
        check("rst_async_stall", 32'(durdur_o), 32'd0);
        check("rst_async_count", 32'(bekleyen_sayisi_o), 32'd0);
        check("rst_async_addr", 32'(yaz_adres_o), 32'd0);
        check("rst_async_data", yaz_veri_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        //            amb_v amb_d          amb_h mem_v mem_d     mem_h wr_v wr_a  wr_d          cnt dd
        // idle after reset
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  0, 5'd0,  32'h0,         2'd0, 0));
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  0, 5'd0,  32'h0,         2'd0, 0));
        // bypass
        tbl.push_back(mk(1, 32'h0000_00AA, 5'd5,  0, 32'h0,     5'd0,  1, 5'd5,  32'h0000_00AA, 2'd0, 0));
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  0, 5'd0,  32'h0,         2'd0, 0));
        // collision: load wins, AMB queued then drained
        tbl.push_back(mk(1, 32'h11,        5'd3,  1, 32'h22,    5'd4,  1, 5'd4,  32'h22,        2'd1, 0));
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  1, 5'd3,  32'h11,        2'd0, 0));
        // fill/stall: third result held by the AMB while durdur_o=1
        tbl.push_back(mk(1, 32'h1,         5'd1,  1, 32'h100,   5'd10, 1, 5'd10, 32'h100,       2'd1, 0));
        tbl.push_back(mk(1, 32'h2,         5'd2,  1, 32'h101,   5'd11, 1, 5'd11, 32'h101,       2'd2, 1));
        tbl.push_back(mk(1, 32'h3,         5'd3,  1, 32'h102,   5'd12, 1, 5'd12, 32'h102,       2'd2, 1));
        tbl.push_back(mk(1, 32'h3,         5'd3,  0, 32'h0,     5'd0,  1, 5'd1,  32'h1,         2'd1, 0));
        tbl.push_back(mk(1, 32'h3,         5'd3,  0, 32'h0,     5'd0,  1, 5'd2,  32'h2,         2'd1, 0));
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  1, 5'd3,  32'h3,         2'd0, 0));
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  0, 5'd0,  32'h0,         2'd0, 0));
        // destination zero on both sources, then x0 AMB result beside a real load
        tbl.push_back(mk(1, 32'hFFFF_FFFF, 5'd0,  1, 32'h55,    5'd0,  0, 5'd0,  32'h0,         2'd0, 0));
        tbl.push_back(mk(1, 32'hFFFF_FFFF, 5'd0,  1, 32'h77,    5'd7,  1, 5'd7,  32'h77,        2'd0, 0));
        tbl.push_back(mk(0, 32'h0,         5'd0,  0, 32'h0,     5'd0,  0, 5'd0,  32'h0,         2'd0, 0));
        // five collisions alternating with idle cycles walk the pointers around twice
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(1, 32'h200 + 32'(k), 5'(16 + k), 1, 32'h300 + 32'(k), 5'(24 + k),
                             1, 5'(24 + k), 32'h300 + 32'(k), 2'd1, 0));
            tbl.push_back(mk(0, 32'h0, 5'd0, 0, 32'h0, 5'd0,
                             1, 5'(16 + k), 32'h200 + 32'(k), 2'd0, 0));
        end
        // fill both entries ahead of the mid-operation reset
        tbl.push_back(mk(1, 32'h500,       5'd9,  1, 32'h400,   5'd8,  1, 5'd8,  32'h400,       2'd1, 0));
        tbl.push_back(mk(1, 32'h501,       5'd13, 1, 32'h401,   5'd14, 1, 5'd14, 32'h401,       2'd2, 1));

        foreach (tbl[i]) begin
            apply(tbl[i], i);
        end

        // Reset mid-cycle with a full FIFO and a write on the port.
        drive_idle();
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_count", 32'(bekleyen_sayisi_o), 32'd0);
        check("rst_mid_stall", 32'(durdur_o), 32'd0);
        check("rst_mid_wr_valid", 32'(yaz_gecerli_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("post_rst%0d_wr_valid", c), 32'(yaz_gecerli_o), 32'd0);
            check($sformatf("post_rst%0d_count", c), 32'(bekleyen_sayisi_o), 32'd0);
            score_write($sformatf("post_rst%0d", c));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
